// File: rtl/lfsr_stream_core.sv
// Galois LFSR word generator with valid/ready output and status readback.
// A word is presented STEPS_PER_WORD+1 edges after the start; m_tvalid and m_tdata are held until the handshake.
module lfsr_stream_core #(
   parameter int                 WIDTH          = 32,
   parameter logic [WIDTH-1:0]   DEFAULT_POLY   = 32'h80200003,
   parameter logic [WIDTH-1:0]   DEFAULT_SEED   = 32'h00000001,
   parameter int                 STEPS_PER_WORD = 1
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic [WIDTH-1:0] cfg_seed,
   input  logic             cfg_seed_load,
   input  logic [WIDTH-1:0] cfg_poly,
   input  logic             cfg_poly_load,
   input  logic             cfg_enable,
   input  logic [15:0]      cfg_burst_len,
   input  logic             cfg_burst_start,
   output logic [WIDTH-1:0] m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             stat_busy,
   output logic             stat_seed_fixed,
   output logic [31:0]      stat_word_cnt
);

   localparam int SCW = $clog2(WIDTH + 1);
   localparam logic [SCW-1:0] LAST_STEP = SCW'(STEPS_PER_WORD - 1);

   typedef enum logic [1:0] {IDLE, STEP, PRESENT} fsm_t;

   fsm_t             fsm_q, fsm_d;
   logic [WIDTH-1:0] state_q, state_d, poly_q, poly_d, tdata_q, tdata_d;
   logic [WIDTH-1:0] pend_seed_q, pend_seed_d, pend_poly_q, pend_poly_d;
   logic             pend_seed_vld_q, pend_seed_vld_d, pend_poly_vld_q, pend_poly_vld_d;
   logic             tvalid_q, tvalid_d, busy_q, busy_d, seed_fixed_q, seed_fixed_d;
   logic             burst_q, burst_d;
   logic [SCW-1:0]   step_cnt_q, step_cnt_d;
   logic [15:0]      remain_q, remain_d;
   logic [31:0]      word_cnt_q, word_cnt_d;
   logic [WIDTH-1:0] shifted, seed_src, poly_src;
   logic             seed_apply, poly_apply;

   always_comb begin
      fsm_d           = fsm_q;
      state_d         = state_q;
      poly_d          = poly_q;
      tdata_d         = tdata_q;
      tvalid_d        = tvalid_q;
      pend_seed_d     = pend_seed_q;
      pend_seed_vld_d = pend_seed_vld_q;
      pend_poly_d     = pend_poly_q;
      pend_poly_vld_d = pend_poly_vld_q;
      seed_fixed_d    = seed_fixed_q;
      burst_d         = burst_q;
      step_cnt_d      = step_cnt_q;
      remain_d        = remain_q;
      word_cnt_d      = word_cnt_q;
      shifted         = (state_q >> 1) ^ (state_q[0] ? poly_q : '0);
      seed_apply      = cfg_seed_load;
      poly_apply      = cfg_poly_load;
      seed_src        = cfg_seed;
      poly_src        = cfg_poly;

      // In PRESENT, loads are held back until the handshake; a fresh pulse beats the pended one.
      if (fsm_q == PRESENT) begin
         if (cfg_seed_load) begin
            pend_seed_vld_d = 1'b1;
            pend_seed_d     = cfg_seed;
         end
         if (cfg_poly_load) begin
            pend_poly_vld_d = 1'b1;
            pend_poly_d     = cfg_poly;
         end
         seed_apply = m_tready && (cfg_seed_load || pend_seed_vld_q);
         poly_apply = m_tready && (cfg_poly_load || pend_poly_vld_q);
         seed_src   = cfg_seed_load ? cfg_seed : pend_seed_q;
         poly_src   = cfg_poly_load ? cfg_poly : pend_poly_q;
      end

      case (fsm_q)
         IDLE: begin
            if (cfg_seed_load || cfg_poly_load) begin
               fsm_d = IDLE;
            end else if (cfg_enable) begin
               fsm_d      = STEP;
               burst_d    = 1'b0;
               step_cnt_d = '0;
            end else if (cfg_burst_start && (cfg_burst_len != 16'd0)) begin
               fsm_d      = STEP;
               burst_d    = 1'b1;
               remain_d   = cfg_burst_len;
               step_cnt_d = '0;
            end
         end
         STEP: begin
            if (cfg_seed_load || cfg_poly_load) begin
               step_cnt_d = '0;
            end else begin
               state_d = shifted;
               if (step_cnt_q == LAST_STEP) begin
                  tdata_d    = shifted;
                  tvalid_d   = 1'b1;
                  step_cnt_d = '0;
                  fsm_d      = PRESENT;
               end else begin
                  step_cnt_d = step_cnt_q + 1'b1;
               end
            end
         end
         PRESENT: begin
            if (m_tready) begin
               tvalid_d        = 1'b0;
               pend_seed_vld_d = 1'b0;
               pend_poly_vld_d = 1'b0;
               if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 32'd1;
               if (burst_q) begin
                  remain_d = remain_q - 16'd1;
                  fsm_d    = (remain_q == 16'd1) ? IDLE : STEP;
               end else begin
                  fsm_d = cfg_enable ? STEP : IDLE;
               end
            end
         end
         default: fsm_d = IDLE;
      endcase

      // Seed load also restarts the delivered-word count.
      if (seed_apply) begin
         state_d      = (seed_src == '0) ? DEFAULT_SEED : seed_src;
         seed_fixed_d = (seed_src == '0);
         word_cnt_d   = '0;
      end
      if (poly_apply) poly_d = poly_src;

      busy_d = (fsm_d != IDLE);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         fsm_q           <= IDLE;
         state_q         <= DEFAULT_SEED;
         poly_q          <= DEFAULT_POLY;
         tdata_q         <= '0;
         tvalid_q        <= 1'b0;
         pend_seed_q     <= '0;
         pend_seed_vld_q <= 1'b0;
         pend_poly_q     <= '0;
         pend_poly_vld_q <= 1'b0;
         busy_q          <= 1'b0;
         seed_fixed_q    <= 1'b0;
         burst_q         <= 1'b0;
         step_cnt_q      <= '0;
         remain_q        <= '0;
         word_cnt_q      <= '0;
      end else begin
         fsm_q           <= fsm_d;
         state_q         <= state_d;
         poly_q          <= poly_d;
         tdata_q         <= tdata_d;
         tvalid_q        <= tvalid_d;
         pend_seed_q     <= pend_seed_d;
         pend_seed_vld_q <= pend_seed_vld_d;
         pend_poly_q     <= pend_poly_d;
         pend_poly_vld_q <= pend_poly_vld_d;
         busy_q          <= busy_d;
         seed_fixed_q    <= seed_fixed_d;
         burst_q         <= burst_d;
         step_cnt_q      <= step_cnt_d;
         remain_q        <= remain_d;
         word_cnt_q      <= word_cnt_d;
      end
   end

   assign m_tdata         = tdata_q;
   assign m_tvalid        = tvalid_q;
   assign stat_busy       = busy_q;
   assign stat_seed_fixed = seed_fixed_q;
   assign stat_word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_core.sv
// Directed bench for lfsr_stream_core; expected words are queued at stimulus time and checked on handshake.
module tb_lfsr_stream_core;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [31:0] cfg_seed = '0;
   logic        cfg_seed_load = 1'b0;
   logic [31:0] cfg_poly = '0;
   logic        cfg_poly_load = 1'b0;
   logic        cfg_enable = 1'b0;
   logic [15:0] cfg_burst_len = '0;
   logic        cfg_burst_start = 1'b0;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        stat_busy;
   logic        stat_seed_fixed;
   logic [31:0] stat_word_cnt;

   int          checks = 0;
   int          failures = 0;
   int          hs_total = 0;
   logic [31:0] exp_q[$];

   lfsr_stream_core dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cfg_seed(cfg_seed), .cfg_seed_load(cfg_seed_load),
      .cfg_poly(cfg_poly), .cfg_poly_load(cfg_poly_load),
      .cfg_enable(cfg_enable), .cfg_burst_len(cfg_burst_len),
      .cfg_burst_start(cfg_burst_start),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .stat_busy(stat_busy), .stat_seed_fixed(stat_seed_fixed),
      .stat_word_cnt(stat_word_cnt)
   );

   always #5 ACLK = ~ACLK;

   // Scoreboard monitor: a handshake happens on the next rising edge when both are high here.
   always @(negedge ACLK) begin
      if (ARESETN && m_tvalid && m_tready) begin
         hs_total = hs_total + 1;
         checks   = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL word_unexpected got=%08h expected=<none>", m_tdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (m_tdata !== e) begin
               failures = failures + 1;
               $display("FAIL word_data got=%08h expected=%08h", m_tdata, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge ACLK);
      #2;
   endtask

   task automatic pulse_seed(input logic [31:0] v);
      cfg_seed      = v;
      cfg_seed_load = 1'b1;
      cyc();
      cfg_seed_load = 1'b0;
   endtask

   task automatic start_burst(input logic [15:0] len);
      cfg_burst_len   = len;
      cfg_burst_start = 1'b1;
      cyc();
      cfg_burst_start = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!m_tvalid && lat < 50) begin
         cyc();
         lat++;
      end
      chk("wait_valid", 32'(m_tvalid), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (stat_busy && n < 100) begin
         cyc();
         n++;
      end
      chk("wait_idle", 32'(stat_busy), 32'd0);
   endtask

   initial begin
      int lat, g, hs0, bad, seen;
      logic [31:0] held;

      #23 ARESETN = 1'b1;
      cyc();
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tdata", m_tdata, 32'h0);
      chk("rst_busy", 32'(stat_busy), 32'd0);
      chk("rst_fixed", 32'(stat_seed_fixed), 32'd0);
      chk("rst_cnt", stat_word_cnt, 32'd0);

      // Continuous mode from reset seed and poly.
      exp_q.push_back(32'h80200003);
      exp_q.push_back(32'hC0300002);
      exp_q.push_back(32'h60180001);
      m_tready   = 1'b1;
      cfg_enable = 1'b1;
      wait_valid(lat);
      chk("first_latency", 32'(lat), 32'd2);
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("gap_tvalid_low", 32'(m_tvalid), 32'd0);
         wait_valid(g);
         chk("word_gap", 32'(g + 1), 32'd2);
      end
      cfg_enable = 1'b0;
      cyc();
      chk("cont_busy_end", 32'(stat_busy), 32'd0);
      chk("cont_tvalid_end", 32'(m_tvalid), 32'd0);
      chk("cont_cnt", stat_word_cnt, 32'd3);

      // Zero seed is replaced by the default seed.
      pulse_seed(32'h0);
      chk("zero_seed_fixed", 32'(stat_seed_fixed), 32'd1);
      chk("zero_seed_cnt", stat_word_cnt, 32'd0);
      exp_q.push_back(32'h80200003);
      start_burst(16'd1);
      wait_valid(lat);
      cyc();
      chk("burst1_cnt", stat_word_cnt, 32'd1);
      chk("burst1_idle", 32'(stat_busy), 32'd0);
      pulse_seed(32'h12345678);
      chk("seed_fixed_clr", 32'(stat_seed_fixed), 32'd0);
      chk("seed_cnt_clr", stat_word_cnt, 32'd0);

      // Burst of three, then a zero-length burst that must be ignored.
      exp_q.push_back(32'h091A2B3C);
      exp_q.push_back(32'h048D159E);
      exp_q.push_back(32'h02468ACF);
      hs0 = hs_total;
      start_burst(16'd3);
      cyc(12);
      chk("burst3_hs", 32'(hs_total - hs0), 32'd3);
      chk("burst3_busy", 32'(stat_busy), 32'd0);
      chk("burst3_tvalid", 32'(m_tvalid), 32'd0);
      chk("burst3_cnt", stat_word_cnt, 32'd3);
      start_burst(16'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         seen = seen | int'(m_tvalid) | int'(stat_busy);
         cyc();
      end
      chk("burst0_ignored", 32'(seen), 32'd0);

      // Backpressure: word held for 10 cycles, then a single handshake.
      m_tready = 1'b0;
      exp_q.push_back(32'h81034564);
      exp_q.push_back(32'h4081A2B2);
      start_burst(16'd2);
      wait_valid(lat);
      held = m_tdata;
      bad  = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (!m_tvalid || m_tdata !== held) bad++;
      end
      chk("hold_stable", 32'(bad), 32'd0);
      chk("hold_data", m_tdata, 32'h81034564);
      hs0 = hs_total;
      m_tready = 1'b1;
      cyc();
      m_tready = 1'b0;
      chk("single_hs", 32'(hs_total - hs0), 32'd1);
      chk("after_hs_tvalid", 32'(m_tvalid), 32'd0);
      cyc();
      chk("next_word_tvalid", 32'(m_tvalid), 32'd1);
      m_tready = 1'b1;
      wait_idle();

      // Seed load during PRESENT is deferred past the current word.
      pulse_seed(32'h1);
      m_tready = 1'b0;
      exp_q.push_back(32'h80200003);
      exp_q.push_back(32'h091A2B3C);
      start_burst(16'd2);
      wait_valid(lat);
      pulse_seed(32'h12345678);
      cyc();
      chk("pend_hold_data", m_tdata, 32'h80200003);
      chk("pend_hold_tvalid", 32'(m_tvalid), 32'd1);
      m_tready = 1'b1;
      wait_idle();

      // Asynchronous reset mid-burst with a word presented.
      m_tready = 1'b0;
      start_burst(16'd5);
      wait_valid(lat);
      chk("pre_rst_cnt_nonzero", 32'(stat_word_cnt != 0), 32'd1);
      ARESETN = 1'b0;
      #1;
      chk("arst_tvalid", 32'(m_tvalid), 32'd0);
      chk("arst_busy", 32'(stat_busy), 32'd0);
      chk("arst_cnt", stat_word_cnt, 32'd0);
      #3 ARESETN = 1'b1;
      cyc();
      m_tready = 1'b1;
      exp_q.push_back(32'h80200003);
      cfg_enable = 1'b1;
      wait_valid(lat);
      chk("post_rst_latency", 32'(lat), 32'd2);
      cfg_enable = 1'b0;
      cyc();
      wait_idle();
      cyc(2);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1);
   end

endmodule
